seq_shr: RTL and testbench

SEQ_SHR -- requirements
Module: seq_shr

---
 rtl/seq_shr.sv | 89 ++++++++
 tb/tb_seq_shr.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seq_shr.sv
// seq_shr: multi-cycle right shifter (logical or arithmetic).
// One log-stage per cycle, so latency is a fixed SW cycles regardless of the shift amount.
module seq_shr #(
  parameter int unsigned DATAWIDTH = 64,
  localparam int unsigned SW = $clog2(DATAWIDTH)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [SW-1:0]        sh_amt,
  input  logic                 arith,
  output logic [DATAWIDTH-1:0] d,
  output logic                 busy,
  output logic                 done
);

  localparam logic [SW-1:0] SW_LAST = SW'(SW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic [SW-1:0]          cnt;
  logic [SW-1:0]          amt;
  logic                   fill;
  logic [DATAWIDTH-1:0]   work;
  logic [DATAWIDTH:0]     ext;
  logic [DATAWIDTH-1:0]   shifted;
  logic [DATAWIDTH-1:0]   stage_val;

  // Current stage result: shift by 2^cnt when that amount bit is set, filling with the captured fill bit.
  always_comb begin
    ext       = {fill, work};
    shifted   = DATAWIDTH'($signed(ext) >>> (32'd1 << cnt));
    stage_val = amt[cnt] ? shifted : work;
  end

  // Control FSM with working registers; d is written only on the edge entering DONE.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      amt   <= '0;
      fill  <= 1'b0;
      work  <= '0;
      d     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            work  <= a;
            amt   <= sh_amt;
            fill  <= arith & a[DATAWIDTH-1];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          work <= stage_val;
          if (cnt == SW_LAST) begin
            d     <= stage_val;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shr.sv
// tb_seq_shr: directed checks of seq_shr at DATAWIDTH=8.
module tb_seq_shr;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;

  logic          Clk;
  logic          Rst;
  logic          start;
  logic [DW-1:0] a;
  logic [SW-1:0] sh_amt;
  logic          arith;
  logic [DW-1:0] d;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  seq_shr #(.DATAWIDTH(DW)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .start  (start),
    .a      (a),
    .sh_amt (sh_amt),
    .arith  (arith),
    .d      (d),
    .busy   (busy),
    .done   (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge where start/inputs were just set; checks the full 3-cycle latency.
  task automatic finish_op(input string tag, input logic [DW-1:0] prev, input logic [DW-1:0] exp);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      start = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      chk({tag, "_hold"}, 32'(d), 32'(prev));
    end
    @(negedge Clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_d"}, 32'(d), 32'(exp));
  endtask

  task automatic run_op(input string tag, input logic [DW-1:0] av, input logic [SW-1:0] sv,
                        input logic ar, input logic [DW-1:0] prev, input logic [DW-1:0] exp);
    @(negedge Clk);
    start = 1'b1; a = av; sh_amt = sv; arith = ar;
    finish_op(tag, prev, exp);
    @(negedge Clk);
    chk({tag, "_pulse1"}, 32'(done), 32'd0);
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; a = '0; sh_amt = '0; arith = 1'b0;
    #12;
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    run_op("lsr3",   8'hB4, 3'd3, 1'b0, 8'h00, 8'h16);
    run_op("asr3",   8'hB4, 3'd3, 1'b1, 8'h16, 8'hF6);
    run_op("asr7",   8'h80, 3'd7, 1'b1, 8'hF6, 8'hFF);
    run_op("lsr7",   8'h80, 3'd7, 1'b0, 8'hFF, 8'h01);
    run_op("sh0",    8'h5A, 3'd0, 1'b0, 8'h01, 8'h5A);
    run_op("asrpos", 8'h5A, 3'd2, 1'b1, 8'h5A, 8'h16);
    run_op("asr5",   8'hC3, 3'd5, 1'b1, 8'h16, 8'hFE);

    // Start while busy is ignored; exactly one done.
    @(negedge Clk);
    start = 1'b1; a = 8'hB4; sh_amt = 3'd3; arith = 1'b0;
    @(negedge Clk);
    a = 8'hFF; sh_amt = 3'd0;
    chk("ign_busy0", 32'(busy), 32'd1);
    @(negedge Clk);
    chk("ign_busy1", 32'(busy), 32'd1);
    @(negedge Clk);
    start = 1'b0;
    chk("ign_busy2", 32'(busy), 32'd1);
    @(negedge Clk);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_d", 32'(d), 32'h16);
    @(negedge Clk);
    chk("ign_pulse1", 32'(done), 32'd0);
    chk("ign_nobusy", 32'(busy), 32'd0);
    chk("ign_dhold", 32'(d), 32'h16);

    // Back-to-back: start held high across DONE.
    @(negedge Clk);
    start = 1'b1; a = 8'hB4; sh_amt = 3'd3; arith = 1'b0;
    @(negedge Clk);
    a = 8'h40; sh_amt = 3'd2;
    chk("b2b_busy0", 32'(busy), 32'd1);
    @(negedge Clk);
    chk("b2b_busy1", 32'(busy), 32'd1);
    @(negedge Clk);
    chk("b2b_busy2", 32'(busy), 32'd1);
    @(negedge Clk);
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_d1", 32'(d), 32'h16);
    finish_op("b2b2", 8'h16, 8'h10);
    @(negedge Clk);
    chk("b2b_pulse1", 32'(done), 32'd0);

    // Async reset mid-operation; start held through reset.
    @(negedge Clk);
    start = 1'b1; a = 8'hB4; sh_amt = 3'd3; arith = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    #2 Rst = 1'b1;
    #1;
    chk("abort_d", 32'(d), 32'd0);
    chk("abort_busy0", 32'(busy), 32'd0);
    chk("abort_done0", 32'(done), 32'd0);
    start = 1'b1; a = 8'h08; sh_amt = 3'd1; arith = 1'b0;
    @(negedge Clk);
    chk("rsthold_busy", 32'(busy), 32'd0);
    chk("rsthold_done", 32'(done), 32'd0);
    Rst = 1'b0;
    finish_op("post_rst", 8'h00, 8'h04);
    @(negedge Clk);
    chk("post_rst_pulse1", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
